// File: rtl/core_task_receiver.sv
// Core-side task dispatch endpoint: captures the scheduler control cycle and instruction
// frames into a local buffer, launches execution and reports Ready when the core is idle.
module core_task_receiver #(
  parameter int CORES_COUNT = 16,
  parameter int CORE_ID     = 0,
  parameter int INSN_COUNT  = 16,
  parameter int INSN_SIZE   = 16,
  parameter int REG_SIZE    = 8,
  parameter int FRAME_DEPTH = 4,
  parameter int ADDR_W      = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CORES_COUNT-1:0]          Start,
  input  logic [CORES_COUNT-1:0]          Init_R0_Vect,
  input  logic [CORES_COUNT*REG_SIZE-1:0] Init_R0,
  input  logic                            Frame_Valid,
  input  logic                            Frame_Last,
  input  logic [INSN_COUNT*INSN_SIZE-1:0] Insn_Data,
  output logic                            Ready,
  output logic                            Exec_Start,
  input  logic                            Exec_Done,
  input  logic [ADDR_W-1:0]               Fetch_Addr,
  output logic [INSN_SIZE-1:0]            Fetch_Insn,
  output logic [ADDR_W:0]                 Insn_Count,
  output logic                            R0_Load,
  output logic [REG_SIZE-1:0]             R0_Value,
  output logic                            Overflow
);

  localparam int FP_W = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
  localparam int WI_W = (INSN_COUNT > 1) ? $clog2(INSN_COUNT) : 1;
  localparam int WP_W = $clog2(FRAME_DEPTH + 1);
  localparam logic [ADDR_W:0] COUNT_MAX  = (ADDR_W+1)'(FRAME_DEPTH * INSN_COUNT);
  localparam logic [ADDR_W:0] COUNT_STEP = (ADDR_W+1)'(INSN_COUNT);
  localparam logic [WP_W-1:0] WP_FULL    = WP_W'(FRAME_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                state_q;
  logic [WP_W-1:0]       wr_ptr_q;
  logic                  ready_q;
  logic                  exec_start_q;
  logic                  r0_load_q;
  logic                  overflow_q;
  logic [REG_SIZE-1:0]   r0_value_q;
  logic [ADDR_W:0]       insn_count_q;
  logic [INSN_SIZE-1:0]  fetch_insn_q;
  logic [INSN_SIZE-1:0]  insn_mem_q [FRAME_DEPTH][INSN_COUNT];

  logic                  sel_me;
  logic                  init_me;
  logic [REG_SIZE-1:0]   r0_slice;
  logic                  buf_full;
  logic                  frame_wr;
  logic [FP_W-1:0]       rd_frame;
  logic [WI_W-1:0]       rd_word;

  function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W:0] cnt);
    logic [ADDR_W+1:0] sum;
    sum = {1'b0, cnt} + {1'b0, COUNT_STEP};
    return (sum > {1'b0, COUNT_MAX}) ? COUNT_MAX : sum[ADDR_W:0];
  endfunction

  assign sel_me   = Start[CORE_ID];
  assign init_me  = Init_R0_Vect[CORE_ID];
  assign r0_slice = Init_R0[CORE_ID*REG_SIZE +: REG_SIZE];
  assign buf_full = (wr_ptr_q == WP_FULL);
  // A frame landing in the same cycle as rst is discarded along with the task.
  assign frame_wr = (state_q == LOAD) && Frame_Valid && !buf_full && !rst;
  assign rd_frame = Fetch_Addr[WI_W +: FP_W];
  assign rd_word  = Fetch_Addr[WI_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      ready_q      <= 1'b0;
      exec_start_q <= 1'b0;
      r0_load_q    <= 1'b0;
      r0_value_q   <= '0;
      insn_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      exec_start_q <= 1'b0;
      r0_load_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_me) begin
            state_q      <= LOAD;
            ready_q      <= 1'b0;
            wr_ptr_q     <= '0;
            insn_count_q <= '0;
            if (init_me) begin
              r0_value_q <= r0_slice;
              r0_load_q  <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          ready_q <= 1'b0;
          if (Frame_Valid) begin
            if (buf_full) begin
              overflow_q <= 1'b1;
            end else begin
              wr_ptr_q     <= wr_ptr_q + 1'b1;
              insn_count_q <= sat_count(insn_count_q);
            end
            if (Frame_Last) begin
              state_q      <= RUN;
              exec_start_q <= 1'b1;
            end
          end
        end
        RUN: begin
          ready_q <= 1'b0;
          if (Exec_Done) state_q <= DONE;
        end
        // One forced not-ready cycle so the scheduler always sees the task complete.
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (frame_wr) begin
      for (int k = 0; k < INSN_COUNT; k++) begin
        insn_mem_q[wr_ptr_q[FP_W-1:0]][k] <= Insn_Data[k*INSN_SIZE +: INSN_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_insn_q <= '0;
    else     fetch_insn_q <= insn_mem_q[rd_frame][rd_word];
  end

  assign Ready      = ready_q;
  assign Exec_Start = exec_start_q;
  assign R0_Load    = r0_load_q;
  assign R0_Value   = r0_value_q;
  assign Insn_Count = insn_count_q;
  assign Fetch_Insn = fetch_insn_q;
  assign Overflow   = overflow_q;

endmodule

// File: tb/tb_core_task_receiver.sv
// Randomized bench for core_task_receiver against a task-level model of the buffer and outputs.
module tb_core_task_receiver;
  localparam int CORES_COUNT = 16;
  localparam int CORE_ID     = 2;
  localparam int INSN_COUNT  = 16;
  localparam int INSN_SIZE   = 16;
  localparam int REG_SIZE    = 8;
  localparam int FRAME_DEPTH = 4;
  localparam int ADDR_W      = 6;
  localparam int WORDS       = FRAME_DEPTH * INSN_COUNT;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [CORES_COUNT-1:0]          Start;
  logic [CORES_COUNT-1:0]          Init_R0_Vect;
  logic [CORES_COUNT*REG_SIZE-1:0] Init_R0;
  logic                            Frame_Valid;
  logic                            Frame_Last;
  logic [INSN_COUNT*INSN_SIZE-1:0] Insn_Data;
  logic                            Ready;
  logic                            Exec_Start;
  logic                            Exec_Done;
  logic [ADDR_W-1:0]               Fetch_Addr;
  logic [INSN_SIZE-1:0]            Fetch_Insn;
  logic [ADDR_W:0]                 Insn_Count;
  logic                            R0_Load;
  logic [REG_SIZE-1:0]             R0_Value;
  logic                            Overflow;

  core_task_receiver #(
    .CORES_COUNT(CORES_COUNT), .CORE_ID(CORE_ID), .INSN_COUNT(INSN_COUNT),
    .INSN_SIZE(INSN_SIZE), .REG_SIZE(REG_SIZE), .FRAME_DEPTH(FRAME_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .Start(Start), .Init_R0_Vect(Init_R0_Vect), .Init_R0(Init_R0),
    .Frame_Valid(Frame_Valid), .Frame_Last(Frame_Last), .Insn_Data(Insn_Data),
    .Ready(Ready), .Exec_Start(Exec_Start), .Exec_Done(Exec_Done), .Fetch_Addr(Fetch_Addr),
    .Fetch_Insn(Fetch_Insn), .Insn_Count(Insn_Count), .R0_Load(R0_Load), .R0_Value(R0_Value),
    .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: buffer contents (with written flags), latched R0 and the sticky overflow flag.
  logic [INSN_SIZE-1:0] mmem [WORDS];
  bit                   mval [WORDS];
  logic [REG_SIZE-1:0]  exp_r0;
  bit                   exp_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CORES_COUNT-1:0] rnd_vec(input bit me);
    logic [CORES_COUNT-1:0] v;
    v = CORES_COUNT'($urandom);
    v[CORE_ID] = me;
    return v;
  endfunction

  function automatic logic [CORES_COUNT*REG_SIZE-1:0] rnd_r0();
    logic [CORES_COUNT*REG_SIZE-1:0] v;
    for (int i = 0; i < CORES_COUNT*REG_SIZE/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [INSN_COUNT*INSN_SIZE-1:0] rnd_frame();
    logic [INSN_COUNT*INSN_SIZE-1:0] v;
    for (int i = 0; i < INSN_COUNT*INSN_SIZE/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic quiet_inputs();
    Start = '0; Init_R0_Vect = '0; Frame_Valid = 1'b0; Frame_Last = 1'b0; Exec_Done = 1'b0;
  endtask

  task automatic run_task(input int nframes, input bit init, input logic [REG_SIZE-1:0] r0v,
                          input int done_delay, input bit gaps);
    int stored;
    int fa;
    bit chk_old;
    logic [INSN_SIZE-1:0] old;
    logic [INSN_COUNT*INSN_SIZE-1:0] fr;
    stored = 0;
    check("ready_idle", 64'(Ready), 64'(1));
    // Control cycle: its frame must be ignored.
    Start = rnd_vec(1'b1); Init_R0_Vect = rnd_vec(init);
    Init_R0 = rnd_r0(); Init_R0[CORE_ID*REG_SIZE +: REG_SIZE] = r0v;
    Frame_Valid = 1'b1; Frame_Last = 1'b1; Insn_Data = rnd_frame(); Exec_Done = 1'b0;
    tick();
    if (init) exp_r0 = r0v;
    check("r0_load", 64'(R0_Load), 64'(init));
    check("r0_value", 64'(R0_Value), 64'(exp_r0));
    check("ready_ctrl", 64'(Ready), 64'(0));
    check("count_ctrl", 64'(Insn_Count), 64'(0));
    for (int f = 0; f < nframes; f++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        Frame_Valid = 1'b0; Frame_Last = 1'b1; Start = rnd_vec(1'b1);
        Init_R0_Vect = rnd_vec(1'b1); Init_R0 = rnd_r0(); Exec_Done = 1'($urandom);
        tick();
        check("gap_count", 64'(Insn_Count), 64'(stored * INSN_COUNT));
        check("gap_ready", 64'(Ready), 64'(0));
        check("gap_r0_load", 64'(R0_Load), 64'(0));
        check("gap_exec_start", 64'(Exec_Start), 64'(0));
      end
      fr = rnd_frame();
      Frame_Valid = 1'b1; Frame_Last = (f == nframes - 1); Insn_Data = fr;
      Start = rnd_vec(1'($urandom)); Init_R0_Vect = rnd_vec(1'b1); Init_R0 = rnd_r0();
      Exec_Done = 1'($urandom);
      fa = (stored < FRAME_DEPTH) ? stored * INSN_COUNT + $urandom_range(0, INSN_COUNT - 1)
                                  : $urandom_range(0, WORDS - 1);
      Fetch_Addr = ADDR_W'(fa); chk_old = mval[fa]; old = mmem[fa];
      tick();
      if (chk_old) check("fetch_old", 64'(Fetch_Insn), 64'(old));
      if (stored < FRAME_DEPTH) begin
        for (int k = 0; k < INSN_COUNT; k++) begin
          mmem[stored*INSN_COUNT + k] = fr[k*INSN_SIZE +: INSN_SIZE];
          mval[stored*INSN_COUNT + k] = 1'b1;
        end
        stored++;
      end else begin
        exp_ovf = 1'b1;
      end
      check("count_load", 64'(Insn_Count), 64'(stored * INSN_COUNT));
      check("overflow", 64'(Overflow), 64'(exp_ovf));
      check("r0_load_in_load", 64'(R0_Load), 64'(0));
      check("r0_value_hold", 64'(R0_Value), 64'(exp_r0));
      check("exec_start", 64'(Exec_Start), 64'(f == nframes - 1));
      check("ready_load", 64'(Ready), 64'(0));
    end
    quiet_inputs();
    for (int d = 0; d <= done_delay; d++) begin
      if (d == done_delay) Exec_Done = 1'b1;
      else begin
        Start = rnd_vec(1'b1); Frame_Valid = 1'b1; Frame_Last = 1'($urandom);
        Insn_Data = rnd_frame();
      end
      fa = (d == 0) ? 17 : $urandom_range(0, WORDS - 1);
      Fetch_Addr = ADDR_W'(fa); chk_old = mval[fa]; old = mmem[fa];
      tick();
      quiet_inputs();
      if (chk_old) check("fetch_run", 64'(Fetch_Insn), 64'(old));
      check("ready_run", 64'(Ready), 64'(0));
      check("exec_start_once", 64'(Exec_Start), 64'(0));
      check("count_run", 64'(Insn_Count), 64'(stored * INSN_COUNT));
    end
    // Now in the single not-ready cycle after completion; Start here is ignored.
    Start = rnd_vec(1'b1); Init_R0_Vect = rnd_vec(1'b1);
    tick();
    check("ready_after_done", 64'(Ready), 64'(1));
    check("r0_load_done", 64'(R0_Load), 64'(0));
    Start = rnd_vec(1'b0); Init_R0_Vect = rnd_vec(1'b1);
    tick();
    check("ready_unselected", 64'(Ready), 64'(1));
    check("r0_load_unselected", 64'(R0_Load), 64'(0));
    quiet_inputs();
  endtask

  task automatic reset_in_load();
    logic [INSN_COUNT*INSN_SIZE-1:0] fr;
    logic [REG_SIZE-1:0] r0v;
    r0v = REG_SIZE'($urandom);
    check("ready_pre_rst", 64'(Ready), 64'(1));
    Start = rnd_vec(1'b1); Init_R0_Vect = rnd_vec(1'b1);
    Init_R0 = rnd_r0(); Init_R0[CORE_ID*REG_SIZE +: REG_SIZE] = r0v;
    tick();
    quiet_inputs();
    fr = rnd_frame(); Frame_Valid = 1'b1; Insn_Data = fr;
    tick();
    for (int k = 0; k < INSN_COUNT; k++) begin
      mmem[k] = fr[k*INSN_SIZE +: INSN_SIZE]; mval[k] = 1'b1;
    end
    check("count_one_frame", 64'(Insn_Count), 64'(INSN_COUNT));
    rst = 1'b1; Frame_Valid = 1'b1; Frame_Last = 1'b1; Insn_Data = rnd_frame();
    tick();
    exp_r0 = '0; exp_ovf = 1'b0;
    check("rst_ready", 64'(Ready), 64'(0));
    check("rst_count", 64'(Insn_Count), 64'(0));
    check("rst_exec_start", 64'(Exec_Start), 64'(0));
    check("rst_r0_value", 64'(R0_Value), 64'(0));
    check("rst_overflow", 64'(Overflow), 64'(0));
    check("rst_fetch", 64'(Fetch_Insn), 64'(0));
    rst = 1'b0; quiet_inputs();
    tick();
    check("rst_release_ready", 64'(Ready), 64'(1));
    check("rst_release_exec_start", 64'(Exec_Start), 64'(0));
    check("rst_release_r0_load", 64'(R0_Load), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) begin mval[i] = 1'b0; mmem[i] = '0; end
    exp_r0 = '0; exp_ovf = 1'b0;
    rst = 1'b1; quiet_inputs(); Init_R0 = '0; Insn_Data = '0; Fetch_Addr = '0;
    tick(); tick(); tick();
    check("reset_ready", 64'(Ready), 64'(0));
    check("reset_exec_start", 64'(Exec_Start), 64'(0));
    check("reset_r0_load", 64'(R0_Load), 64'(0));
    check("reset_r0_value", 64'(R0_Value), 64'(0));
    check("reset_count", 64'(Insn_Count), 64'(0));
    check("reset_fetch", 64'(Fetch_Insn), 64'(0));
    check("reset_overflow", 64'(Overflow), 64'(0));
    rst = 1'b0;
    tick();
    check("reset_release_ready", 64'(Ready), 64'(1));

    run_task(2, 1'b1, 8'hA5, 5, 1'b0);
    run_task(5, 1'b0, 8'h3C, 0, 1'b0);
    for (int t = 0; t < 25; t++) begin
      run_task($urandom_range(1, 6), 1'($urandom), REG_SIZE'($urandom),
               $urandom_range(0, 6), 1'($urandom));
    end
    reset_in_load();
    run_task(3, 1'b1, REG_SIZE'($urandom), 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/core_task_receiver.md
Name: core_task_receiver

Overview:
- Core-side endpoint of the scheduler-to-core task dispatch interface; one instance per core, selected by CORE_ID.
- Captures the broadcast control cycle (start bit, optional R0 init) and the following instruction frames into a local instruction buffer.
- Starts local execution once the buffer is loaded and reports Ready back to the scheduler when execution completes.

Parameters:
- CORES_COUNT, 16, width of the broadcast Start / Init_R0_Vect vectors.
- CORE_ID, 0, index of this core in the broadcast vectors.
- INSN_COUNT, 16, instructions per frame.
- INSN_SIZE, 16, bits per instruction.
- REG_SIZE, 8, R0 width.
- FRAME_DEPTH, 4, frames held in the local buffer; power of two.
- ADDR_W, 6, log2(FRAME_DEPTH*INSN_COUNT); width of the fetch address.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- Start  in  CORES_COUNT  scheduler control-cycle core select; bit CORE_ID addresses this core.
- Init_R0_Vect  in  CORES_COUNT  bit CORE_ID set: load R0 from Init_R0 in the control cycle.
- Init_R0  in  CORES_COUNT*REG_SIZE  R0 init values; slice CORE_ID*REG_SIZE +: REG_SIZE.
- Frame_Valid  in  1  Insn_Data holds a valid instruction frame this cycle.
- Frame_Last  in  1  qualifies Frame_Valid; marks the final frame of the task.
- Insn_Data  in  INSN_COUNT*INSN_SIZE  frame; instruction k at bits k*INSN_SIZE +: INSN_SIZE.
- Ready  out  1  core idle and able to accept a task; goes to the scheduler Ready[CORE_ID].
- Exec_Start  out  1  one-cycle pulse to the core pipeline: buffer loaded, begin at address 0.
- Exec_Done  in  1  core pipeline finished the task; sampled only in RUN.
- Fetch_Addr  in  ADDR_W  instruction buffer read address.
- Fetch_Insn  out  INSN_SIZE  buffer word at Fetch_Addr; registered, 1-cycle latency.
- Insn_Count  out  ADDR_W+1  instructions loaded = frames_loaded*INSN_COUNT.
- R0_Load  out  1  one-cycle pulse: write R0_Value into core R0.
- R0_Value  out  REG_SIZE  latched Init_R0 slice.
- Overflow  out  1  sticky: a frame arrived with the buffer full; cleared only by rst.

Behaviour:
- Reset values: Ready=0, Exec_Start=0, R0_Load=0, R0_Value=0, Insn_Count=0, Fetch_Insn=0, Overflow=0; state=IDLE; wr_ptr=0. Buffer contents are not reset.
- Ready is registered and equals (state==IDLE). It first reads 1 in the cycle after rst deasserts.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Start[CORE_ID]=1 is the control cycle. Clear wr_ptr and Insn_Count; go to LOAD; Ready reads 0 from the next cycle.
  - If Init_R0_Vect[CORE_ID]=1 in that cycle, latch the Init_R0 slice into R0_Value and pulse R0_Load next cycle.
  - Frame_Valid is ignored in IDLE, including during the control cycle; the control cycle carries no instructions.
- LOAD:
  - On each Frame_Valid, write frame words into buffer addresses wr_ptr*INSN_COUNT + k; wr_ptr++; Insn_Count += INSN_COUNT.
  - Frame_Valid & Frame_Last: write that frame, go to RUN, pulse Exec_Start in the first RUN cycle.
  - Buffer full (wr_ptr==FRAME_DEPTH) and Frame_Valid: drop the frame and set Overflow. No pointer wrap. If Frame_Last is also set, still go to RUN.
  - Start is ignored in LOAD.
- RUN:
  - Start and Frame_Valid are ignored. Exec_Done=1 leads to DONE.
  - Exec_Done coincident with Exec_Start is honoured (zero-length task).
- DONE: unconditional 1-cycle state, then IDLE. This guarantees the scheduler samples Ready=0 for at least one cycle per task.
- Fetch: Fetch_Insn <= buf[Fetch_Addr] every cycle, in any state.
  - Write/read same address in the same cycle returns the old data.
  - Addresses at or above Insn_Count return stale data; no error.
- Insn_Count saturates at FRAME_DEPTH*INSN_COUNT.
- rst mid-operation (any state) returns to IDLE with reset output values. No Exec_Start or R0_Load pulse escapes after rst.
- Start with bit CORE_ID=0 has no effect in any state.

Test Plan:
- Reset release → Ready 0 during rst, 1 in the first cycle after rst drops; all other outputs 0.
- Control cycle Start=16'h0004 (CORE_ID=2), Init_R0_Vect=16'h0004, slice=8'hA5; then 2 frames, last flagged → R0_Load pulse with R0_Value=8'hA5; Insn_Count=32; Exec_Start one cycle after the last frame; Fetch_Addr=17 returns frame1 insn1 one cycle later.
- Exec_Done asserted 5 cycles after Exec_Start → Ready=1 exactly 2 cycles after Exec_Done (DONE then IDLE); a second Start is accepted only from that cycle.
- 5 frames with FRAME_DEPTH=4, last flagged → first 4 stored, Overflow=1, Insn_Count=64, Exec_Start still pulses.
- Start[CORE_ID]=1 asserted during LOAD and RUN → no state change, R0 not reloaded; Init_R0_Vect bit 0 in the control cycle → no R0_Load pulse.
- rst asserted in LOAD after 1 frame → next cycle IDLE, Insn_Count=0, no Exec_Start; Ready=1 after rst drops.
